csr_regfile: RTL and testbench

Control/status register file for the five-stage LoongArch pipeline. Terminates the `to_csr_bus` that the writeback stage drives: performs masked CSR writes, commits exception and `ertn` state changes, and answers combinational reads on `csr_rdata`. It also owns the constant timer, the 64-bit stable counter and interrupt detection, and returns the exception entry, the return PC and the pending-interrupt flag to the front of the pipeline.

---
 rtl/csr_regfile_pkg.sv | 114 +++++++++++
 rtl/csr_timer.sv | 51 +++++
 rtl/csr_regfile.sv | 163 ++++++++++++++++
 tb/tb_csr_regfile.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the CSR file: bus layout, CSR numbers, exception
// bitmap indices and their Ecode/EsubCode, plus the masked-write and cause helpers.
package csr_regfile_pkg;

  localparam int unsigned TO_CSR_BUS     = 161;
  localparam int unsigned EXCEPTION_CODE = 13;

  localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int unsigned EX_INT  = 0;
  localparam int unsigned EX_ADEF = 1;
  localparam int unsigned EX_TLBR = 2;
  localparam int unsigned EX_PIF  = 3;
  localparam int unsigned EX_PPI  = 4;
  localparam int unsigned EX_INE  = 5;
  localparam int unsigned EX_IPE  = 6;
  localparam int unsigned EX_SYS  = 7;
  localparam int unsigned EX_BRK  = 8;
  localparam int unsigned EX_ALE  = 9;
  localparam int unsigned EX_ADEM = 10;
  localparam int unsigned EX_PIL  = 11;
  localparam int unsigned EX_PIS  = 12;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_IPE  = 6'h0e;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  typedef enum logic [1:0] {
    BADV_KEEP,
    BADV_PC,
    BADV_VADDR
  } badv_src_e;

  typedef struct packed {
    logic [5:0] ecode;
    logic [8:0] esubcode;
    badv_src_e  badv_src;
  } ex_cause_t;

  typedef struct packed {
    logic                      tlbrd;
    logic                      tlbwr;
    logic                      tlbfill;
    logic [31:0]               data_vaddr;
    logic                      csr_we;
    logic [13:0]               csr_num;
    logic [31:0]               csr_mask;
    logic [31:0]               csr_wdata;
    logic                      ertn;
    logic                      ex;
    logic [EXCEPTION_CODE-1:0] ex_code;
    logic [31:0]               pc;
  } to_csr_bus_t;

  function automatic logic [31:0] mask_write(input logic [31:0] old_v,
                                             input logic [31:0] mask,
                                             input logic [31:0] wdata);
    return (old_v & ~mask) | (wdata & mask);
  endfunction

  // Isolate the lowest set bit first so the lowest index wins on multi-bit bitmaps.
  function automatic ex_cause_t decode_ex(input logic [EXCEPTION_CODE-1:0] code);
    ex_cause_t                 c;
    logic [EXCEPTION_CODE-1:0] low;
    low = code & (~code + 13'd1);
    c   = '{ecode: ECODE_INT, esubcode: ESUBCODE_ADEF, badv_src: BADV_KEEP};
    case (low)
      (13'd1 << EX_ADEF): c = '{ecode: ECODE_ADE,  esubcode: ESUBCODE_ADEF, badv_src: BADV_PC};
      (13'd1 << EX_TLBR): c = '{ecode: ECODE_TLBR, esubcode: '0, badv_src: BADV_PC};
      (13'd1 << EX_PIF):  c = '{ecode: ECODE_PIF,  esubcode: '0, badv_src: BADV_PC};
      (13'd1 << EX_PPI):  c = '{ecode: ECODE_PPI,  esubcode: '0, badv_src: BADV_VADDR};
      (13'd1 << EX_INE):  c.ecode = ECODE_INE;
      (13'd1 << EX_IPE):  c.ecode = ECODE_IPE;
      (13'd1 << EX_SYS):  c.ecode = ECODE_SYS;
      (13'd1 << EX_BRK):  c.ecode = ECODE_BRK;
      (13'd1 << EX_ALE):  c = '{ecode: ECODE_ALE,  esubcode: '0, badv_src: BADV_VADDR};
      (13'd1 << EX_ADEM): c = '{ecode: ECODE_ADE,  esubcode: ESUBCODE_ADEM, badv_src: BADV_VADDR};
      (13'd1 << EX_PIL):  c = '{ecode: ECODE_PIL,  esubcode: '0, badv_src: BADV_VADDR};
      (13'd1 << EX_PIS):  c = '{ecode: ECODE_PIS,  esubcode: '0, badv_src: BADV_VADDR};
      (13'd1 << EX_INT):  c.ecode = ECODE_INT;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: TVAL down-counter with one-shot/periodic reload and the
// sticky timer-interrupt flag (TI) cleared through TICLR.
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_clr,
  output logic [31:0] tval,
  output logic        ti
);

  logic        armed;
  logic        periodic;
  logic [29:0] init_val;
  logic        expire;

  // A TCFG write in the same cycle takes precedence over an expiry.
  assign expire = armed & ~tcfg_we & (tval == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tval     <= '0;
      armed    <= 1'b0;
      periodic <= 1'b0;
      init_val <= '0;
      ti       <= 1'b0;
    end else begin
      if (tcfg_we) begin
        init_val <= tcfg_wdata[31:2];
        periodic <= tcfg_wdata[1];
        armed    <= tcfg_wdata[0];
        tval     <= {tcfg_wdata[31:2], 2'b00};
      end else if (armed) begin
        if (tval != '0)
          tval <= tval - 32'd1;
        else if (periodic)
          tval <= {init_val, 2'b00};
        else
          armed <= 1'b0;
      end
      if (expire)
        ti <= 1'b1;
      else if (ticlr_clr)
        ti <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// LoongArch CSR file: masked CSR writes, exception/ertn commit, interrupt
// detection, constant timer and 64-bit stable counter.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TO_CSR_BUS-1:0] to_csr_bus,
  input  logic [7:0]            hw_int,
  output logic [31:0]           csr_rdata,
  output logic [31:0]           ex_entry,
  output logic [31:0]           era_pc,
  output logic                  has_int,
  output logic [63:0]           stable_counter
);

  to_csr_bus_t bus;
  ex_cause_t   cause;
  logic        wr_en;
  logic        unused_bus;

  logic [1:0]       plv, pplv;
  logic             ie, da, pie;
  logic [12:0]      lie;
  logic [1:0]       is_sw;
  logic [7:0]       is_hw;
  logic [5:0]       ecode;
  logic [8:0]       esubcode;
  logic [31:0]      era, badv, tid, tcfg;
  logic [25:0]      eentry;
  logic [3:0][31:0] save;
  logic [63:0]      cnt;

  logic [31:0] tval;
  logic        ti;
  logic        tcfg_we, ticlr_clr;

  logic [31:0] crmd_v, prmd_v, ecfg_v, estat_v, eentry_v;
  logic [12:0] is_v;
  logic [31:0] rdata_cur, wnew;

  assign bus        = to_csr_bus;
  assign unused_bus = ^{bus.tlbrd, bus.tlbwr, bus.tlbfill};
  assign cause      = decode_ex(bus.ex_code);
  assign wr_en      = bus.csr_we & ~bus.ex & ~bus.ertn;

  assign crmd_v   = {28'h0, da, ie, plv};
  assign prmd_v   = {29'h0, pie, pplv};
  assign ecfg_v   = {19'h0, lie};
  assign is_v     = {1'b0, ti, 1'b0, is_hw, is_sw};
  assign estat_v  = {1'b0, esubcode, ecode, 3'b000, is_v};
  assign eentry_v = {eentry, 6'b0};

  always_comb begin
    rdata_cur = '0;
    case (bus.csr_num)
      CSR_CRMD:   rdata_cur = crmd_v;
      CSR_PRMD:   rdata_cur = prmd_v;
      CSR_ECFG:   rdata_cur = ecfg_v;
      CSR_ESTAT:  rdata_cur = estat_v;
      CSR_ERA:    rdata_cur = era;
      CSR_BADV:   rdata_cur = badv;
      CSR_EENTRY: rdata_cur = eentry_v;
      CSR_SAVE0:  rdata_cur = save[0];
      CSR_SAVE1:  rdata_cur = save[1];
      CSR_SAVE2:  rdata_cur = save[2];
      CSR_SAVE3:  rdata_cur = save[3];
      CSR_TID:    rdata_cur = tid;
      CSR_TCFG:   rdata_cur = tcfg;
      CSR_TVAL:   rdata_cur = tval;
      CSR_TICLR:  rdata_cur = '0;
      default:    rdata_cur = '0;
    endcase
  end

  // The read mux already selects the addressed CSR, so its masked merge is the
  // new value for whichever register is being written; each register keeps only its own fields.
  assign csr_rdata = rdata_cur;
  assign wnew      = mask_write(rdata_cur, bus.csr_mask, bus.csr_wdata);

  assign tcfg_we   = wr_en & (bus.csr_num == CSR_TCFG);
  assign ticlr_clr = wr_en & (bus.csr_num == CSR_TICLR) & wnew[0];

  csr_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .tcfg_we    (tcfg_we),
    .tcfg_wdata (wnew),
    .ticlr_clr  (ticlr_clr),
    .tval       (tval),
    .ti         (ti)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {da, ie, plv} <= CRMD_RESET[3:0];
      pplv     <= '0;
      pie      <= 1'b0;
      lie      <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      badv     <= '0;
      eentry   <= '0;
      save     <= '0;
      tid      <= TID_INIT;
      tcfg     <= '0;
    end else begin
      is_hw <= hw_int;
      if (bus.ex) begin
        pplv     <= plv;
        pie      <= ie;
        plv      <= '0;
        ie       <= 1'b0;
        era      <= bus.pc;
        ecode    <= cause.ecode;
        esubcode <= cause.esubcode;
        case (cause.badv_src)
          BADV_PC:    badv <= bus.pc;
          BADV_VADDR: badv <= bus.data_vaddr;
          default: ;
        endcase
      end else if (bus.ertn) begin
        plv <= pplv;
        ie  <= pie;
      end else if (bus.csr_we) begin
        case (bus.csr_num)
          CSR_CRMD:   {da, ie, plv} <= wnew[3:0];
          CSR_PRMD:   {pie, pplv}   <= wnew[2:0];
          CSR_ECFG:   lie           <= wnew[12:0];
          CSR_ESTAT:  is_sw         <= wnew[1:0];
          CSR_ERA:    era           <= wnew;
          CSR_BADV:   badv          <= wnew;
          CSR_EENTRY: eentry        <= wnew[31:6];
          CSR_SAVE0:  save[0]       <= wnew;
          CSR_SAVE1:  save[1]       <= wnew;
          CSR_SAVE2:  save[2]       <= wnew;
          CSR_SAVE3:  save[3]       <= wnew;
          CSR_TID:    tid           <= wnew;
          CSR_TCFG:   tcfg          <= wnew;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt + 64'd1;
  end

  assign ex_entry       = eentry_v;
  assign era_pc         = era;
  assign has_int        = ie & (|(is_v & lie));
  assign stable_counter = cnt;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed literal checks plus randomized
// traffic compared every cycle against a word-level behavioural model.
module tb_csr_regfile;

  localparam logic [31:0] TID_V = 32'h1234_5678;

  localparam logic [13:0] N_CRMD = 14'h000, N_PRMD = 14'h001, N_ECFG = 14'h004,
                          N_ESTAT = 14'h005, N_ERA = 14'h006, N_BADV = 14'h007,
                          N_EENTRY = 14'h00c, N_SAVE1 = 14'h031, N_TID = 14'h040,
                          N_TCFG = 14'h041, N_TVAL = 14'h042, N_TICLR = 14'h044;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  b_tlb = '0;
  logic [31:0] b_vaddr = '0, b_mask = '0, b_wdata = '0, b_pc = '0;
  logic        b_we = 1'b0, b_ertn = 1'b0, b_ex = 1'b0;
  logic [13:0] b_num = '0;
  logic [12:0] b_code = '0;
  logic [7:0]  hw_int = '0;
  logic [160:0] bus;
  logic [31:0] csr_rdata, ex_entry, era_pc;
  logic        has_int;
  logic [63:0] stable_counter;

  assign bus = {b_tlb, b_vaddr, b_we, b_num, b_mask, b_wdata, b_ertn, b_ex, b_code, b_pc};

  always #5 clk = ~clk;

  csr_regfile #(.TID_INIT(TID_V)) dut (
    .clk            (clk),
    .reset          (reset),
    .to_csr_bus     (bus),
    .hw_int         (hw_int),
    .csr_rdata      (csr_rdata),
    .ex_entry       (ex_entry),
    .era_pc         (era_pc),
    .has_int        (has_int),
    .stable_counter (stable_counter)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mreg [logic [13:0]];
  logic [31:0] m_tval;
  bit          m_armed, m_ti;
  logic [7:0]  m_hw;
  logic [63:0] m_cnt;

  logic [5:0] EC_TBL  [13] = '{6'h00, 6'h08, 6'h3f, 6'h03, 6'h07, 6'h0d, 6'h0e,
                               6'h0b, 6'h0c, 6'h09, 6'h08, 6'h01, 6'h02};
  logic [8:0] SUB_TBL [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int         SRC_TBL [13] = '{0, 1, 1, 1, 2, 0, 0, 0, 0, 2, 2, 2, 2};

  function automatic logic [31:0] wmask(input logic [13:0] n);
    case (n)
      14'h000: return 32'h0000_000f;
      14'h001: return 32'h0000_0007;
      14'h004: return 32'h0000_1fff;
      14'h005: return 32'h0000_0003;
      14'h00c: return 32'hffff_ffc0;
      14'h006, 14'h007, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040, 14'h041:
        return 32'hffff_ffff;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] n);
    case (n)
      14'h005: return (mreg[14'h005] & 32'h7fff_0003) | {20'h0, m_ti, 1'b0, m_hw, 2'b00};
      14'h042: return m_tval;
      default: return mreg.exists(n) ? mreg[n] : 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    logic [31:0] e, l, c;
    e = m_read(14'h005);
    l = mreg[14'h004];
    c = mreg[14'h000];
    return c[2] & (|(e[12:0] & l[12:0]));
  endfunction

  task automatic model_reset();
    logic [13:0] keys [13] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                               14'h00c, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040, 14'h041};
    mreg.delete();
    foreach (keys[k]) mreg[keys[k]] = 32'h0;
    mreg[14'h000] = 32'h8;
    mreg[14'h040] = TID_V;
    m_tval = 0; m_armed = 0; m_ti = 0; m_hw = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [31:0] crmd, prmd, tcfg_old, tc_new, wm;
    bit we_ok, tcfg_wr, ticlr, ti_set;
    int w;
    crmd     = mreg[14'h000];
    prmd     = mreg[14'h001];
    tcfg_old = mreg[14'h041];
    we_ok    = b_we && !b_ex && !b_ertn;
    tcfg_wr  = we_ok && (b_num == N_TCFG);
    ticlr    = we_ok && (b_num == N_TICLR) && b_mask[0] && b_wdata[0];
    ti_set   = 0;
    m_cnt    = m_cnt + 1;
    if (tcfg_wr) begin
      tc_new  = (tcfg_old & ~b_mask) | (b_wdata & b_mask);
      m_tval  = tc_new & ~32'h3;
      m_armed = tc_new[0];
    end else if (m_armed) begin
      if (m_tval != 0) m_tval = m_tval - 1;
      else begin
        ti_set = 1;
        if (tcfg_old[1]) m_tval = tcfg_old & ~32'h3;
        else m_armed = 0;
      end
    end
    if (ti_set) m_ti = 1;
    else if (ticlr) m_ti = 0;
    m_hw = hw_int;
    if (b_ex) begin
      w = -1;
      for (int i = 0; i < 13; i++) if (b_code[i] && w < 0) w = i;
      mreg[14'h001] = crmd & 32'h7;
      mreg[14'h000] = crmd & ~32'h7;
      mreg[14'h006] = b_pc;
      if (w >= 0) begin
        mreg[14'h005] = (mreg[14'h005] & ~32'h7fff_0000) | {1'b0, SUB_TBL[w], EC_TBL[w], 16'h0};
        if (SRC_TBL[w] == 1) mreg[14'h007] = b_pc;
        else if (SRC_TBL[w] == 2) mreg[14'h007] = b_vaddr;
      end else
        mreg[14'h005] = mreg[14'h005] & ~32'h7fff_0000;
    end else if (b_ertn) begin
      mreg[14'h000] = (crmd & ~32'h7) | (prmd & 32'h7);
    end else if (we_ok) begin
      wm = wmask(b_num) & b_mask;
      if (wm != 0) mreg[b_num] = (mreg[b_num] & ~wm) | (b_wdata & wm);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("csr_rdata", csr_rdata, m_read(b_num));
      check("ex_entry", ex_entry, mreg[14'h00c]);
      check("era_pc", era_pc, mreg[14'h006]);
      check("has_int", has_int, m_has_int());
      check("stable_counter", stable_counter, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic idle();
    b_we = 0; b_ex = 0; b_ertn = 0; b_code = '0; b_mask = '0; b_wdata = '0;
  endtask

  task automatic csr_write(input logic [13:0] n, input logic [31:0] m, input logic [31:0] d);
    b_we = 1; b_num = n; b_mask = m; b_wdata = d;
    tick();
    idle();
  endtask

  task automatic do_ex(input logic [12:0] code, input logic [31:0] pc, input logic [31:0] va);
    b_ex = 1; b_code = code; b_pc = pc; b_vaddr = va;
    tick();
    idle();
  endtask

  task automatic rd(input string name, input logic [13:0] n, input logic [31:0] exp);
    b_num = n;
    #1;
    check(name, csr_rdata, exp);
  endtask

  logic [13:0] rnd_nums [18] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                 14'h00c, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040,
                                 14'h041, 14'h042, 14'h044, 14'h002, 14'h043, 14'h1ff};

  initial begin
    model_reset();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("counter_after_reset", stable_counter, 64'd0);
    rd("crmd_reset", N_CRMD, 32'h8);
    rd("tid_reset", N_TID, TID_V);
    check("has_int_reset", has_int, 64'd0);
    tick();
    check("counter_1", stable_counter, 64'd1);
    tick();
    check("counter_2", stable_counter, 64'd2);

    // masked write, then a write blocked by ex
    csr_write(N_SAVE1, 32'h0000_ffff, 32'ha5a5_a5a5);
    rd("save1_masked", N_SAVE1, 32'h0000_a5a5);
    b_we = 1; b_num = N_SAVE1; b_mask = '1; b_wdata = 32'hdead_beef;
    b_ex = 1; b_code = 13'h080; b_pc = 32'h1c00_0000;
    tick();
    idle();
    rd("save1_ex_blocked", N_SAVE1, 32'h0000_a5a5);

    // SYS then ertn
    csr_write(N_CRMD, 32'h7, 32'h7);
    rd("crmd_plv3_ie", N_CRMD, 32'hf);
    do_ex(13'h080, 32'h1c00_0100, 32'h0);
    rd("crmd_after_sys", N_CRMD, 32'h8);
    rd("prmd_after_sys", N_PRMD, 32'h7);
    check("era_after_sys", era_pc, 64'h1c00_0100);
    rd("estat_sys", N_ESTAT, 32'h000b_0000);
    b_ertn = 1; tick(); idle();
    rd("crmd_after_ertn", N_CRMD, 32'hf);

    // ALE together with SYS, then ALE alone
    do_ex(13'h280, 32'h1c00_0200, 32'h3);
    rd("estat_sys_wins", N_ESTAT, 32'h000b_0000);
    rd("badv_unchanged", N_BADV, 32'h0);
    do_ex(13'h200, 32'h1c00_0300, 32'h3);
    rd("estat_ale", N_ESTAT, 32'h0009_0000);
    rd("badv_ale", N_BADV, 32'h3);

    // periodic timer
    csr_write(N_TCFG, '1, 32'h13);
    rd("tval_load", N_TVAL, 32'd16);
    for (int k = 15; k >= 0; k--) begin
      tick();
      rd("tval_count", N_TVAL, 32'(k));
    end
    tick();
    rd("tval_reload", N_TVAL, 32'd16);
    rd("estat_ti_set", N_ESTAT, 32'h0009_0800);
    csr_write(N_ECFG, '1, 32'h800);
    csr_write(N_CRMD, '1, 32'hc);
    check("has_int_timer", has_int, 64'd1);
    csr_write(N_TICLR, '1, 32'h1);
    rd("estat_ti_clear", N_ESTAT, 32'h0009_0000);
    check("has_int_cleared", has_int, 64'd0);

    // one-shot timer
    csr_write(N_TCFG, '1, 32'h9);
    rd("oneshot_load", N_TVAL, 32'd8);
    repeat (8) tick();
    rd("oneshot_zero", N_TVAL, 32'd0);
    tick();
    rd("oneshot_ti", N_ESTAT, 32'h0009_0800);
    rd("oneshot_tval_hold", N_TVAL, 32'd0);
    csr_write(N_TICLR, 32'h1, 32'h1);
    repeat (20) tick();
    rd("oneshot_no_retrigger", N_ESTAT, 32'h0009_0000);
    rd("oneshot_tval_still0", N_TVAL, 32'd0);

    // hardware interrupt line
    csr_write(N_ECFG, '1, 32'h4);
    hw_int = 8'h01;
    tick();
    rd("estat_hw", N_ESTAT, 32'h0009_0004);
    check("has_int_hw", has_int, 64'd1);
    hw_int = 8'h00;

    // reset mid-count
    csr_write(N_TCFG, '1, 32'h13);
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    #1;
    check("counter_mid_reset", stable_counter, 64'd0);
    rd("tval_mid_reset", N_TVAL, 32'd0);
    rd("crmd_mid_reset", N_CRMD, 32'h8);
    repeat (2) tick();
    reset = 1'b0;

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      b_tlb   = 3'($urandom);
      b_num   = rnd_nums[$urandom_range(0, 17)];
      b_we    = ($urandom_range(0, 1) == 0);
      b_mask  = ($urandom_range(0, 3) == 0) ? $urandom : 32'hffff_ffff;
      b_wdata = (b_num == N_TCFG) ? 32'($urandom_range(0, 127)) : $urandom;
      b_ex    = ($urandom_range(0, 9) == 0);
      b_ertn  = ($urandom_range(0, 9) == 0);
      b_code  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : (13'd1 << $urandom_range(0, 12));
      if (b_code == '0) b_code = 13'h080;
      b_pc    = $urandom;
      b_vaddr = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
      if (c == 800) begin
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
      end else
        tick();
    end
    idle();
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
